cond_unit: RTL and testbench

- Condition/flag stage directly downstream of the ALU in the single-cycle ARM datapath.
- Holds the architectural NZCV status register and updates it from ALUFlags under FlagW control.
- Evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's PCS/RegW/MemW strobes into the final PCSrc/RegWrite/MemWrite, and supplies the stored carry for ADC/SBC/RSC.

---
 rtl/cond_unit_pkg.sv | 44 ++++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_unit.sv | 62 ++++++
 tb/tb_cond_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_unit_pkg.sv
// Shared constants for the condition/flag stage.
// The ALU and the decoder use the same encodings, so all of them are kept here.
package cond_unit_pkg;

    // ARM condition field, instruction bits [31:28]
    typedef logic [3:0] cond_t;

    localparam cond_t COND_EQ = 4'b0000;
    localparam cond_t COND_NE = 4'b0001;
    localparam cond_t COND_CS = 4'b0010;
    localparam cond_t COND_CC = 4'b0011;
    localparam cond_t COND_MI = 4'b0100;
    localparam cond_t COND_PL = 4'b0101;
    localparam cond_t COND_VS = 4'b0110;
    localparam cond_t COND_VC = 4'b0111;
    localparam cond_t COND_HI = 4'b1000;
    localparam cond_t COND_LS = 4'b1001;
    localparam cond_t COND_GE = 4'b1010;
    localparam cond_t COND_LT = 4'b1011;
    localparam cond_t COND_GT = 4'b1100;
    localparam cond_t COND_LE = 4'b1101;
    localparam cond_t COND_AL = 4'b1110;
    // Unconditional space is unsupported here and treated as never-execute
    localparam cond_t COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bit meanings: [1] writes the N,Z pair, [0] writes the C,V pair
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    // Structured view of the flag vector, same bit order as {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: Cond + {N,Z,C,V} -> CondEx.
// Holds no state so it can be dropped into a pipelined datapath unchanged.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    flags_t f;
    logic   ge;

    assign f  = flags_t'(flags);
    // Signed "greater or equal" holds when N and V agree
    assign ge = (f.n == f.v);

    // Decode the condition field against the stored flags; every encoding is defined
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = f.z;
            COND_NE: cond_ex = ~f.z;
            COND_CS: cond_ex = f.c;
            COND_CC: cond_ex = ~f.c;
            COND_MI: cond_ex = f.n;
            COND_PL: cond_ex = ~f.n;
            COND_VS: cond_ex = f.v;
            COND_VC: cond_ex = ~f.v;
            COND_HI: cond_ex = f.c & ~f.z;
            COND_LS: cond_ex = ~f.c | f.z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~f.z & ge;
            COND_LE: cond_ex = f.z | ~ge;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition/flag stage behind the ALU of the single-cycle ARM datapath.
// Owns the NZCV register, evaluates the condition field against it and gates
// the decoder write strobes. Flag updates are seen by the next instruction only.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags,
    output logic       CarryIn
);

    logic cond_ex;
    logic write_nz;
    logic write_cv;

    // Condition is always judged on the stored (pre-update) flags
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (cond_ex)
    );

    // A failed condition suppresses the flag write as well as the strobes
    assign write_nz = FlagW[FLAGW_NZ] & cond_ex;
    assign write_cv = FlagW[FLAGW_CV] & cond_ex;

    // Flag register: reset wins over any write, each pair updates independently
    always_ff @(posedge clk) begin
        if (!reset) begin
            Flags <= RESET_FLAGS;
        end else begin
            if (write_nz) begin
                Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (write_cv) begin
                Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & cond_ex;
    // Compare-type instructions only set flags, so the register write is dropped
    assign RegWrite = RegW & cond_ex & ~NoWrite;
    assign MemWrite = MemW & cond_ex;
    assign CarryIn  = Flags[FLAG_C];

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios followed by random
// instructions, all compared against a behavioural model of the flag stage.
module tb_cond_unit;

    localparam logic [3:0] RESET_VAL = 4'b0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
    logic       CarryIn;

    int checks   = 0;
    int failures = 0;

    // Model state: architectural flags as the model believes them to be
    logic [3:0] m_flags;

    cond_unit #(.RESET_FLAGS(RESET_VAL)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags),
        .CarryIn  (CarryIn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Condition semantics written in terms of what the flags mean
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, signed_ge;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        signed_ge = (n == v);
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return signed_ge;
            4'd11: return !signed_ge;
            4'd12: return !z && signed_ge;
            4'd13: return z || !signed_ge;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        logic ce;
        #1;
        ce = model_cond(Cond, m_flags);
        chk({tag, "_condex"},   {3'b0, CondEx},   {3'b0, ce});
        chk({tag, "_pcsrc"},    {3'b0, PCSrc},    {3'b0, PCS & ce});
        chk({tag, "_regwrite"}, {3'b0, RegWrite}, {3'b0, RegW & ce & !NoWrite});
        chk({tag, "_memwrite"}, {3'b0, MemWrite}, {3'b0, MemW & ce});
        chk({tag, "_flags"},    Flags,            m_flags);
        chk({tag, "_carryin"},  {3'b0, CarryIn},  {3'b0, m_flags[1]});
    endtask

    // Advance one instruction; the model applies the flag write the DUT should take
    task automatic clock_step();
        logic [3:0] nxt;
        nxt = m_flags;
        if (!reset) begin
            nxt = RESET_VAL;
        end else if (model_cond(Cond, m_flags)) begin
            if (FlagW[1]) nxt[3:2] = ALUFlags[3:2];
            if (FlagW[0]) nxt[1:0] = ALUFlags[1:0];
        end
        @(posedge clk);
        #1;
        m_flags = nxt;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                         input logic pcs, input logic rw, input logic mw, input logic nw);
        Cond     = c;
        FlagW    = fw;
        ALUFlags = af;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
        NoWrite  = nw;
    endtask

    // Load the flag register with a known value through an AL instruction
    task automatic load_flags(input logic [3:0] val);
        drive(4'b1110, 2'b11, val, 1'b0, 1'b0, 1'b0, 1'b0);
        clock_step();
    endtask

    initial begin
        m_flags = 4'bxxxx;
        reset   = 1'b0;
        drive(4'b1110, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held for two clocks with a full flag write pending
        clock_step();
        clock_step();
        #1;
        chk("reset_flags", Flags, 4'b0000);
        chk("reset_carry", {3'b0, CarryIn}, 4'b0000);
        reset = 1'b1;
        drive(4'b0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_eq_condex", {3'b0, CondEx}, 4'b0000);
        check_outputs("after_reset");

        // Split write: N,Z pair then C,V pair
        drive(4'b1110, 2'b10, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        clock_step();
        #1;
        chk("split_nz", Flags, 4'b0100);
        drive(4'b1110, 2'b01, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        clock_step();
        #1;
        chk("split_cv", Flags, 4'b0111);
        chk("split_carry", {3'b0, CarryIn}, 4'b0001);

        // Compare-type instruction: flags update, register write suppressed
        drive(4'b1110, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
        chk("cmp_condex", {3'b0, CondEx}, 4'b0001);
        clock_step();
        drive(4'b0000, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cmp_eq_pcsrc", {3'b0, PCSrc}, 4'b0001);
        Cond = 4'b1000;
        #1;
        chk("cmp_hi_condex", {3'b0, CondEx}, 4'b0000);
        check_outputs("cmp_hi");

        // Failed condition suppresses strobes and the flag write
        load_flags(4'b0000);
        drive(4'b0000, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("supp_pcsrc", {3'b0, PCSrc}, 4'b0000);
        chk("supp_regwrite", {3'b0, RegWrite}, 4'b0000);
        chk("supp_memwrite", {3'b0, MemWrite}, 4'b0000);
        clock_step();
        #1;
        chk("supp_flags", Flags, 4'b0000);

        // Every flag value against every condition code
        for (int fv = 0; fv < 16; fv++) begin
            load_flags(4'(fv));
            for (int c = 0; c < 16; c++) begin
                drive(4'(c), 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
                check_outputs("sweep");
            end
        end

        // Signed-condition spot checks
        load_flags(4'b1001);
        drive(4'b1010, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("spot_ge", {3'b0, CondEx}, 4'b0001);
        Cond = 4'b1011;
        #1;
        chk("spot_lt", {3'b0, CondEx}, 4'b0000);
        Cond = 4'b1100;
        #1;
        chk("spot_gt", {3'b0, CondEx}, 4'b0001);
        load_flags(4'b1000);
        Cond  = 4'b1101;
        FlagW = 2'b00;
        #1;
        chk("spot_le", {3'b0, CondEx}, 4'b0001);
        load_flags(4'b1111);
        Cond  = 4'b1111;
        FlagW = 2'b00;
        #1;
        chk("spot_nv", {3'b0, CondEx}, 4'b0000);

        // Reset in the middle of a flag-writing instruction
        drive(4'b1110, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        clock_step();
        #1;
        chk("midreset_flags", Flags, RESET_VAL);
        reset = 1'b1;

        // Random instruction stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 15) != 0);
            drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_outputs("rand");
            clock_step();
        end
        reset = 1'b1;
        #1;
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
